// File: rtl/roic_sync_scheduler.sv
// roic_sync_scheduler: arbitrates FSM/register triggers and times ROIC_SYNC, the TP select window and hold-off.
// Optional grant counter (sync_count, stats_clr) enabled by macro ROIC_SYNC_STATS_EN.
module roic_sync_scheduler #(
    parameter int SYNC_W = 8,
    parameter int TP_W   = 16,
    parameter int HOLD_W = 8
) (
    input  logic              clk_20mhz,
    input  logic              rst_20mhz,
    input  logic [SYNC_W-1:0] cfg_sync_width,
    input  logic [7:0]        cfg_tp_delay,
    input  logic [TP_W-1:0]   cfg_tp_width,
    input  logic [HOLD_W-1:0] cfg_holdoff,
    input  logic              cfg_tp_en,
    input  logic              reg_req,
    input  logic              fsm_req,
    output logic              fsm_ack,
    output logic              reg_ack,
    output logic              reg_pending,
    output logic              busy,
    output logic              done,
    output logic              roic_sync,
    output logic              roic_tp_sel
`ifdef ROIC_SYNC_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       sync_count
`endif
);

    // One shared phase counter, wide enough for any of the phase lengths.
    localparam int W1    = (SYNC_W > TP_W) ? SYNC_W : TP_W;
    localparam int W2    = (W1 > HOLD_W) ? W1 : HOLD_W;
    localparam int CNT_W = (W2 > 8) ? W2 : 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_TP_DLY = 3'd2,
        S_TP_WIN = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               grant_fsm;
    logic               grant_reg;
    logic               grant;

    logic               tp_go_q, tp_go_d;
    logic [7:0]         tp_delay_q, tp_delay_d;
    logic [TP_W-1:0]    tp_width_q, tp_width_d;
    logic [HOLD_W-1:0]  holdoff_q, holdoff_d;

    state_t             tail_state;
    logic [CNT_W-1:0]   tail_cnt;

    logic               fsm_ack_q, fsm_ack_d;
    logic               reg_ack_q, reg_ack_d;
    logic               reg_pending_q, reg_pending_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               roic_sync_q, roic_sync_d;
    logic               roic_tp_sel_q, roic_tp_sel_d;

    assign grant = grant_fsm | grant_reg;

    // Where the sequence goes once the sync/TP phases are finished.
    always_comb begin
        tail_state = S_IDLE;
        tail_cnt   = '0;
        if (holdoff_q != '0) begin
            tail_state = S_HOLD;
            tail_cnt   = CNT_W'(holdoff_q) - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_fsm = 1'b0;
        grant_reg = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_fsm = fsm_req;
                grant_reg = !fsm_req && (reg_pending_q || reg_req);
                if (fsm_req || reg_pending_q || reg_req) begin
                    state_d = S_SYNC;
                    cnt_d   = (cfg_sync_width == '0) ? '0
                                                     : CNT_W'(cfg_sync_width) - CNT_W'(1);
                end
            end
            S_SYNC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (tp_go_q && (tp_delay_q != '0)) begin
                    state_d = S_TP_DLY;
                    cnt_d   = CNT_W'(tp_delay_q) - CNT_W'(1);
                end else if (tp_go_q) begin
                    state_d = S_TP_WIN;
                    cnt_d   = CNT_W'(tp_width_q) - CNT_W'(1);
                end else begin
                    state_d = tail_state;
                    cnt_d   = tail_cnt;
                end
            end
            S_TP_DLY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_TP_WIN;
                    cnt_d   = CNT_W'(tp_width_q) - CNT_W'(1);
                end
            end
            S_TP_WIN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = tail_state;
                    cnt_d   = tail_cnt;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with the state register.
    always_comb begin
        fsm_ack_d     = grant_fsm;
        reg_ack_d     = grant_reg;
        roic_sync_d   = (state_d == S_SYNC);
        roic_tp_sel_d = (state_d == S_TP_WIN);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_q != S_IDLE) && (state_d == S_IDLE);
        reg_pending_d = grant_reg ? 1'b0 : (reg_pending_q | reg_req);
    end

    // Config is frozen at the grant so mid-sequence changes cannot disturb timing.
    always_comb begin
        tp_go_d    = tp_go_q;
        tp_delay_d = tp_delay_q;
        tp_width_d = tp_width_q;
        holdoff_d  = holdoff_q;
        if (grant) begin
            tp_go_d    = cfg_tp_en && (cfg_tp_width != '0);
            tp_delay_d = cfg_tp_delay;
            tp_width_d = cfg_tp_width;
            holdoff_d  = cfg_holdoff;
        end
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) begin
            fsm_ack_q     <= 1'b0;
            reg_ack_q     <= 1'b0;
            reg_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            roic_sync_q   <= 1'b0;
            roic_tp_sel_q <= 1'b0;
            tp_go_q       <= 1'b0;
            tp_delay_q    <= '0;
            tp_width_q    <= '0;
            holdoff_q     <= '0;
        end else begin
            fsm_ack_q     <= fsm_ack_d;
            reg_ack_q     <= reg_ack_d;
            reg_pending_q <= reg_pending_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            roic_sync_q   <= roic_sync_d;
            roic_tp_sel_q <= roic_tp_sel_d;
            tp_go_q       <= tp_go_d;
            tp_delay_q    <= tp_delay_d;
            tp_width_q    <= tp_width_d;
            holdoff_q     <= holdoff_d;
        end
    end

    assign fsm_ack     = fsm_ack_q;
    assign reg_ack     = reg_ack_q;
    assign reg_pending = reg_pending_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign roic_sync   = roic_sync_q;
    assign roic_tp_sel = roic_tp_sel_q;

`ifdef ROIC_SYNC_STATS_EN
    logic [15:0] sync_count_q, sync_count_d;

    // Clear beats a same-cycle grant; the count sticks at all-ones.
    always_comb begin
        sync_count_d = sync_count_q;
        if (stats_clr) begin
            sync_count_d = '0;
        end else if (grant && (sync_count_q != 16'hFFFF)) begin
            sync_count_d = sync_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) begin
            sync_count_q <= '0;
        end else begin
            sync_count_q <= sync_count_d;
        end
    end

    assign sync_count = sync_count_q;
`endif

endmodule

// File: tb/tb_roic_sync_scheduler.sv
// Bench for roic_sync_scheduler: per-cycle trace model built from phase lengths, randomized configs.
module tb_roic_sync_scheduler;

    logic        clk_20mhz;
    logic        rst_20mhz;
    logic [7:0]  cfg_sync_width;
    logic [7:0]  cfg_tp_delay;
    logic [15:0] cfg_tp_width;
    logic [7:0]  cfg_holdoff;
    logic        cfg_tp_en;
    logic        reg_req;
    logic        fsm_req;
    logic        fsm_ack;
    logic        reg_ack;
    logic        reg_pending;
    logic        busy;
    logic        done;
    logic        roic_sync;
    logic        roic_tp_sel;
`ifdef ROIC_SYNC_STATS_EN
    logic        stats_clr;
    logic [15:0] sync_count;
`endif

    roic_sync_scheduler dut (
        .clk_20mhz      (clk_20mhz),
        .rst_20mhz      (rst_20mhz),
        .cfg_sync_width (cfg_sync_width),
        .cfg_tp_delay   (cfg_tp_delay),
        .cfg_tp_width   (cfg_tp_width),
        .cfg_holdoff    (cfg_holdoff),
        .cfg_tp_en      (cfg_tp_en),
        .reg_req        (reg_req),
        .fsm_req        (fsm_req),
        .fsm_ack        (fsm_ack),
        .reg_ack        (reg_ack),
        .reg_pending    (reg_pending),
        .busy           (busy),
        .done           (done),
        .roic_sync      (roic_sync),
        .roic_tp_sel    (roic_tp_sel)
`ifdef ROIC_SYNC_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .sync_count     (sync_count)
`endif
    );

    initial begin
        clk_20mhz = 1'b0;
        forever #25 clk_20mhz = ~clk_20mhz;
    end

    int vectors;
    int miscompares;

    // Observed vector: {reg_pending, fsm_ack, reg_ack, roic_sync, roic_tp_sel, busy, done}
    logic [6:0] obs;
    assign obs = {reg_pending, fsm_ack, reg_ack, roic_sync, roic_tp_sel, busy, done};

    logic [6:0] exp_q[$];

    // Expected per-cycle trace of one granted sequence, starting in the ack cycle.
    function automatic void add_seq(bit src_fsm, int sw, bit en, int dly, int tpw, int hold, bit pend);
        int ns;
        ns = (sw == 0) ? 1 : sw;
        for (int i = 0; i < ns; i++)
            exp_q.push_back({pend, (i == 0) && src_fsm, (i == 0) && !src_fsm, 1'b1, 1'b0, 1'b1, 1'b0});
        if (en && (tpw != 0)) begin
            for (int i = 0; i < dly; i++) exp_q.push_back({pend, 6'b000010});
            for (int i = 0; i < tpw; i++) exp_q.push_back({pend, 6'b000110});
        end
        for (int i = 0; i < hold; i++) exp_q.push_back({pend, 6'b000010});
        exp_q.push_back({pend, 6'b000001});
    endfunction

    task automatic set_cfg(int sw, bit en, int dly, int tpw, int hold);
        cfg_sync_width = 8'(sw);
        cfg_tp_en      = en;
        cfg_tp_delay   = 8'(dly);
        cfg_tp_width   = 16'(tpw);
        cfg_holdoff    = 8'(hold);
    endtask

    task automatic scramble_cfg();
        set_cfg($urandom_range(0, 9), 1'($urandom_range(0, 1)), $urandom_range(0, 9),
                $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    task automatic test_reset();
        rst_20mhz = 1'b1;
        repeat (3) @(negedge clk_20mhz);
        vectors++;
        if (obs !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", obs, 7'b0);
        end
        rst_20mhz = 1'b0;
        @(negedge clk_20mhz);
        vectors++;
        if (obs !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", obs, 7'b0);
        end
        set_cfg(4, 1'b0, 0, 0, 0);
        exp_q = {};
        add_seq(1'b0, 4, 1'b0, 0, 0, 0, 1'b0);
        exp_q.push_back(7'b0);
        reg_req = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk_20mhz);
            if (i == 0) reg_req = 1'b0;
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_first_seq cyc %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_full_sequence();
        set_cfg(2, 1'b1, 3, 5, 2);
        exp_q = {};
        add_seq(1'b1, 2, 1'b1, 3, 5, 2, 1'b0);
        exp_q.push_back(7'b0);
        fsm_req = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk_20mhz);
            if (i == 0) fsm_req = 1'b0;
            if (i == 1) scramble_cfg();
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL full_seq cyc %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_cfg();
        // {sw, en, dly, tpw, hold}
        int tbl[4][5] = '{'{0, 0, 0, 0, 0}, '{3, 1, 2, 0, 1}, '{1, 1, 0, 2, 0}, '{0, 1, 0, 1, 0}};
        for (int t = 0; t < 4; t++) begin
            set_cfg(tbl[t][0], 1'(tbl[t][1]), tbl[t][2], tbl[t][3], tbl[t][4]);
            exp_q = {};
            add_seq(1'b1, tbl[t][0], 1'(tbl[t][1]), tbl[t][2], tbl[t][3], tbl[t][4], 1'b0);
            exp_q.push_back(7'b0);
            fsm_req = 1'b1;
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk_20mhz);
                if (i == 0) begin
                    fsm_req = 1'b0;
                    scramble_cfg();
                end
                vectors++;
                if (obs !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL zero_cfg[%0d] cyc %0d: got %b expected %b", t, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int sw, dly, tpw, hold;
        bit en;
        sw = $urandom_range(0, 4); en = 1'($urandom_range(0, 1));
        dly = $urandom_range(0, 3); tpw = $urandom_range(0, 4); hold = $urandom_range(0, 3);
        set_cfg(sw, en, dly, tpw, hold);
        exp_q = {};
        add_seq(1'b1, sw, en, dly, tpw, hold, 1'b1);
        add_seq(1'b0, sw, en, dly, tpw, hold, 1'b0);
        exp_q.push_back(7'b0);
        fsm_req = 1'b1;
        reg_req = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk_20mhz);
            if (i == 0) begin
                fsm_req = 1'b0;
                reg_req = 1'b0;
            end
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL simultaneous cyc %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_pending_while_busy();
        set_cfg(6, 1'b0, 0, 0, 1);
        exp_q = {};
        add_seq(1'b1, 6, 1'b0, 0, 0, 1, 1'b1);
        exp_q[0] = exp_q[0] & 7'h3f;
        add_seq(1'b0, 6, 1'b0, 0, 0, 1, 1'b0);
        repeat (4) exp_q.push_back(7'b0);
        fsm_req = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk_20mhz);
            if (i == 0) fsm_req = 1'b0;
            reg_req = (i == 0) || (i == 2);
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL pending_busy cyc %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int sw, dly, tpw, hold;
        bit en, src;
        for (int n = 0; n < 20; n++) begin
            sw = $urandom_range(0, 5); en = 1'($urandom_range(0, 1)); src = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 4); tpw = $urandom_range(0, 6); hold = $urandom_range(0, 3);
            set_cfg(sw, en, dly, tpw, hold);
            exp_q = {};
            add_seq(src, sw, en, dly, tpw, hold, 1'b0);
            exp_q.push_back(7'b0);
            fsm_req = src;
            reg_req = !src;
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk_20mhz);
                if (i == 0) begin
                    fsm_req = 1'b0;
                    reg_req = 1'b0;
                    scramble_cfg();
                end
                vectors++;
                if (obs !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random[%0d] cyc %0d: got %b expected %b", n, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        set_cfg(2, 1'b1, 1, 6, 2);
        exp_q = {};
        add_seq(1'b1, 2, 1'b1, 1, 6, 2, 1'b1);
        exp_q[0] = exp_q[0] & 7'h3f;
        fsm_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_20mhz);
            if (i == 0) fsm_req = 1'b0;
            reg_req = (i == 0);
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL mid_reset_pre cyc %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
        rst_20mhz = 1'b1;
        @(negedge clk_20mhz);
        vectors++;
        if (obs !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_reset_edge: got %b expected %b", obs, 7'b0);
        end
        rst_20mhz = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_20mhz);
            vectors++;
            if (obs !== 7'b0) begin
                miscompares++;
                $display("FAIL mid_reset_after cyc %0d: got %b expected %b", i, obs, 7'b0);
            end
        end
    endtask

`ifdef ROIC_SYNC_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b1;
        @(negedge clk_20mhz);
        stats_clr = 1'b0;
        vectors++;
        if (sync_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_clr_idle: got %0d expected 0", sync_count);
        end
        set_cfg(1, 1'b0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            fsm_req = 1'b1;
            @(negedge clk_20mhz);
            fsm_req = 1'b0;
            @(negedge clk_20mhz);
        end
        vectors++;
        if (sync_count !== 16'd3) begin
            miscompares++;
            $display("FAIL stats_three_grants: got %0d expected 3", sync_count);
        end
        fsm_req = 1'b1;
        stats_clr = 1'b1;
        @(negedge clk_20mhz);
        fsm_req = 1'b0;
        stats_clr = 1'b0;
        vectors++;
        if (sync_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_clr_vs_grant: got %0d expected 0", sync_count);
        end
        repeat (2) @(negedge clk_20mhz);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_20mhz   = 1'b1;
        reg_req     = 1'b0;
        fsm_req     = 1'b0;
`ifdef ROIC_SYNC_STATS_EN
        stats_clr   = 1'b0;
`endif
        set_cfg(0, 1'b0, 0, 0, 0);
        test_reset();
        test_full_sequence();
        test_zero_cfg();
        test_simultaneous();
        test_pending_while_busy();
        test_random();
        test_mid_reset();
`ifdef ROIC_SYNC_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/roic_sync_scheduler.md
Name: roic_sync_scheduler

Overview:
- Sequences ROIC_SYNC and ROIC_TP_SEL for the TI ROIC interface. Produces one timed sync pulse, an optional test-pulse select window, and a hold-off per granted request.
- Arbitrates between two requesters: the register block (one-shot software trigger) and the sequencer FSM (level request with ack).
- Outputs are registered. They feed the control mux stage ahead of ti_roic_integration.

Parameters:
- SYNC_W, 8: width of the sync pulse-length config and counter.
- TP_W, 16: width of the TP window config and counter.
- HOLD_W, 8: width of the hold-off config and counter.

Ports:
- clk_20mhz  in  1  system 20 MHz clock. This is the block's only clock.
- rst_20mhz  in  1  reset. Synchronous, active-high.
- cfg_sync_width  in  SYNC_W  sync pulse length in cycles. 0 is treated as 1.
- cfg_tp_delay  in  8  cycles from sync fall to TP window start. 0 means no delay.
- cfg_tp_width  in  TP_W  TP window length in cycles. 0 means no window.
- cfg_holdoff  in  HOLD_W  idle guard cycles after the sequence. 0 means none.
- cfg_tp_en  in  1  enables the TP phase.
- reg_req  in  1  register trigger. Single-cycle pulse.
- fsm_req  in  1  FSM request. Level; held high until fsm_ack.
- fsm_ack  out  1  1-cycle grant to the FSM.
- reg_ack  out  1  1-cycle grant to the register requester.
- reg_pending  out  1  a register trigger is latched and waiting.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  1-cycle pulse on return to IDLE.
- roic_sync  out  1  ROIC sync output. Registered.
- roic_tp_sel  out  1  TP select output. Registered.

Behaviour:
- Reset: state=IDLE and all counters 0. Every output is 0, including reg_pending, which is cleared.
- Reset mid-sequence: outputs drop to 0 on the next clock edge. No done pulse is generated.
- reg_req latching: sets reg_pending in every state.
  - reg_pending clears only on reg_ack.
  - Additional reg_req while already pending is absorbed; at most one pending.
- Arbitration, evaluated in IDLE only:
  - fsm_req has priority.
  - If fsm_req and reg_pending (or reg_req) are both present, the FSM is granted and reg_pending stays set.
  - The register request is served in the next IDLE after hold-off.
- Config latching: all cfg_* values are captured on the grant cycle. Changes mid-sequence have no effect.
- States and transitions:
  - IDLE: on grant at edge N, assert the matching ack for one cycle (N+1). roic_sync=1 from N+1. Go to SYNC.
  - SYNC: roic_sync high for max(cfg_sync_width,1) cycles. Then go to TP_DLY if cfg_tp_en and cfg_tp_width≠0; otherwise go to HOLD.
  - TP_DLY: cfg_tp_delay cycles with both outputs low. If cfg_tp_delay=0 the state is skipped, so roic_tp_sel rises in the cycle after roic_sync falls.
  - TP_WIN: roic_tp_sel high for exactly cfg_tp_width cycles. Then go to HOLD.
  - HOLD: cfg_holdoff cycles with outputs low (0 = state skipped). Then go to IDLE with done=1 for one cycle.
  - A new grant is possible in the cycle after done.
- Output timing:
  - roic_sync and roic_tp_sel are never high in the same cycle.
  - Both are glitch-free flop outputs.
- fsm_ack timing: a held fsm_req after fsm_ack is treated as a new request. The FSM must drop fsm_req in the cycle after fsm_ack.
- Counter arithmetic:
  - Down-counters load (value−1) and terminate at 0.
  - Counters do not wrap: the maximum count equals the config value.

Optional Feature:
- Macro ROIC_SYNC_STATS_EN.
- When defined, add output sync_count[15:0], incremented on every grant and saturating at 0xFFFF.
- Add input stats_clr, a synchronous clear that wins over a same-cycle increment.
- Both are cleared by rst_20mhz.
- When not defined, neither port exists and no counter logic is present.

Test Plan:
- Reset check: assert rst_20mhz for 3 cycles -> all outputs 0 and reg_pending=0. Then pulse reg_req with sync_width=4, tp_en=0, holdoff=0 -> reg_ack at N+1, roic_sync high for exactly 4 cycles, done 1 cycle after sync falls.
- Full sequence: fsm_req with sync_width=2, tp_en=1, tp_delay=3, tp_width=5, holdoff=2 -> sync high 2 cycles, 3 low cycles, tp_sel high 5 cycles, 2 idle cycles, then done. busy is high from N+1 through the cycle before done.
- Simultaneous requests: fsm_req and reg_req in the same IDLE cycle -> fsm_ack first and reg_pending=1. reg_ack occurs in the cycle after the first done, and the second sequence follows.
- Zero-config boundaries:
  - sync_width=0 -> 1-cycle sync.
  - tp_en=1, tp_width=0 -> no tp_sel.
  - tp_delay=0 -> tp_sel rises in the cycle after sync falls.
  - cfg changed mid-sequence -> no effect.
- Mid-sequence reset and pending: assert rst_20mhz during TP_WIN -> tp_sel=0 on the next edge, no done, state IDLE. Two reg_req pulses while busy -> exactly one further sequence.
- ROIC_SYNC_STATS_EN: 3 grants -> sync_count=3. stats_clr coincident with a grant -> 0. Preload near saturation -> stays at 0xFFFF.
